// File: rtl/playback_pkg.sv
// Shared definitions for the playback sequencer: FSM state codes,
// direction level encoding and the half-word select used when a
// 32-bit flash word is split into two 16-bit audio samples.
package playback_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_WAIT_DATA = 2'd2;
  localparam logic [1:0] ST_HALF      = 2'd3;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_BWD = 1'b0;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  function automatic logic [15:0] pick_half(input logic [31:0] word, input logic sel);
    return (sel == HALF_HI) ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/addr_counter.sv
// Flash word-address counter: loads the song start for the current
// direction, steps up or down, and at the end of the song either wraps
// (PLAYBACK_CTRL_LOOP_EN defined) or holds its value.
module addr_counter import playback_pkg::*; #(
  parameter int                ADDR_W    = 23,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic              dir,
  output logic [ADDR_W-1:0] addr,
  output logic              at_end
);

  localparam logic [ADDR_W-1:0] ONE  = 1;
  localparam logic [ADDR_W-1:0] ZERO = '0;

  assign at_end = (dir == DIR_FWD) ? (addr == LAST_ADDR) : (addr == ZERO);

  // Load has priority over stepping; a step at the end wraps or holds
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= ZERO;
    end else if (load) begin
      addr <= (dir == DIR_FWD) ? ZERO : LAST_ADDR;
    end else if (en) begin
      if (!at_end) begin
        addr <= (dir == DIR_FWD) ? addr + ONE : addr - ONE;
      end
`ifdef PLAYBACK_CTRL_LOOP_EN
      else begin
        addr <= (dir == DIR_FWD) ? ZERO : LAST_ADDR;
      end
`endif
    end
  end

endmodule

// File: rtl/playback_ctrl.sv
// Playback sequencer for the simple iPod: one flash word read per two
// audio ticks, one 16-bit sample out per tick, forward or backward.
// Define PLAYBACK_CTRL_LOOP_EN to make the song loop at either end;
// otherwise playback stops at the end until a restart.
module playback_ctrl import playback_pkg::*; #(
  parameter int                ADDR_W    = 23,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              direction,
  input  logic              restart,
  input  logic              sample_tick,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic              flash_waitrequest,
  input  logic              flash_readdatavalid,
  input  logic [31:0]       flash_readdata,
  output logic [15:0]       audio_data,
  output logic              audio_valid,
  output logic              overrun
);

  logic [1:0]  state;
  logic        restart_pend;
  logic        stopped;
  logic        half_sel;
  logic [31:0] word_reg;
  logic        restart_any;
  logic        apply_restart;
  logic        play_tick;
  logic        advance;
  logic        at_end;

  // A restart seen now or earlier suppresses ticks; it only takes effect
  // outside a read so the flash bus transaction is never abandoned
  assign restart_any   = restart | restart_pend;
  assign apply_restart = restart_pend && ((state == ST_IDLE) || (state == ST_HALF));
  assign play_tick     = sample_tick && start && !stopped && !restart_any;
  assign advance       = (state == ST_HALF) && play_tick;
  assign flash_read    = (state == ST_REQ);

  addr_counter #(
    .ADDR_W    (ADDR_W),
    .LAST_ADDR (LAST_ADDR)
  ) u_addr_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (apply_restart),
    .en     (advance),
    .dir    (direction),
    .addr   (flash_addr),
    .at_end (at_end)
  );

  // Main sequencer: request, wait for data, emit first half, then the other half
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      restart_pend <= 1'b0;
      half_sel     <= HALF_LO;
      word_reg     <= '0;
      audio_data   <= '0;
      audio_valid  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      if (restart) begin
        restart_pend <= 1'b1;
      end
      if (apply_restart) begin
        state        <= ST_IDLE;
        overrun      <= 1'b0;
        restart_pend <= restart;
      end else begin
        case (state)
          ST_IDLE: begin
            if (play_tick) begin
              state <= ST_REQ;
            end
          end
          ST_REQ: begin
            if (sample_tick) begin
              overrun <= 1'b1;
            end
            if (!flash_waitrequest) begin
              state <= ST_WAIT_DATA;
            end
          end
          ST_WAIT_DATA: begin
            if (sample_tick) begin
              overrun <= 1'b1;
            end
            if (flash_readdatavalid) begin
              if (restart_any) begin
                state <= ST_IDLE;
              end else begin
                state       <= ST_HALF;
                word_reg    <= flash_readdata;
                audio_valid <= 1'b1;
                if (direction == DIR_FWD) begin
                  audio_data <= flash_readdata[15:0];
                  half_sel   <= HALF_HI;
                end else begin
                  audio_data <= flash_readdata[31:16];
                  half_sel   <= HALF_LO;
                end
              end
            end
          end
          default: begin
            if (play_tick) begin
              audio_data  <= pick_half(word_reg, half_sel);
              audio_valid <= 1'b1;
              state       <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

`ifdef PLAYBACK_CTRL_LOOP_EN
  assign stopped = 1'b0;
`else
  // Latch end-of-song so further ticks are ignored until a restart
  always_ff @(posedge clk) begin
    if (reset) begin
      stopped <= 1'b0;
    end else if (apply_restart) begin
      stopped <= 1'b0;
    end else if (advance && at_end) begin
      stopped <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_playback_ctrl.sv
// Directed testbench for playback_ctrl with a small flash slave model
// (programmable stall and read latency) and an output monitor.
module tb_playback_ctrl;

  localparam logic [22:0] LAST = 23'h7FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        direction = 1'b1;
  logic        restart = 1'b0;
  logic        sample_tick = 1'b0;
  logic        flash_read;
  logic [22:0] flash_addr;
  logic        flash_waitrequest = 1'b0;
  logic        flash_readdatavalid = 1'b0;
  logic [31:0] flash_readdata = '0;
  logic [15:0] audio_data;
  logic        audio_valid;
  logic        overrun;

  int tests_run = 0;
  int tests_failed = 0;

  int          av_count = 0;
  int          rd_count = 0;
  int          addr_glitch = 0;
  logic [15:0] last_audio = '0;
  logic [22:0] last_rd_addr = '0;
  logic        prev_read = 1'b0;
  logic [22:0] prev_addr = '0;

  logic        acc_n = 1'b0;
  logic [22:0] acc_addr = '0;
  int          stall_left = 0;
  int          lat_extra = 0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [22:0] pend_addr = '0;

  playback_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .direction           (direction),
    .restart             (restart),
    .sample_tick         (sample_tick),
    .flash_read          (flash_read),
    .flash_addr          (flash_addr),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdatavalid (flash_readdatavalid),
    .flash_readdata      (flash_readdata),
    .audio_data          (audio_data),
    .audio_valid         (audio_valid),
    .overrun             (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    case (a)
      23'd0:   return 32'hBBBB_AAAA;
      23'd5:   return 32'h2222_1111;
      default: return {a[15:0] ^ 16'hF0F0, a[15:0]};
    endcase
  endfunction

  // Monitor: sample everything mid-cycle, record accepted reads and samples
  always @(negedge clk) begin
    acc_n    = flash_read && !flash_waitrequest;
    acc_addr = flash_addr;
    if (audio_valid) begin
      av_count++;
      last_audio = audio_data;
    end
    if (acc_n) begin
      rd_count++;
      last_rd_addr = flash_addr;
    end
    if (flash_read && prev_read && (flash_addr != prev_addr)) addr_glitch++;
    prev_read = flash_read;
    prev_addr = flash_addr;
  end

  // Flash slave: stall a newly raised request, return data after latency
  always @(posedge clk) begin
    #1;
    flash_readdatavalid = 1'b0;
    if (acc_n) begin
      pend      = 1'b1;
      pend_cnt  = lat_extra;
      pend_addr = acc_addr;
    end
    if (pend) begin
      if (pend_cnt == 0) begin
        flash_readdatavalid = 1'b1;
        flash_readdata      = mem_word(pend_addr);
        pend                = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    flash_waitrequest = flash_read && (stall_left > 0);
    if (flash_waitrequest) stall_left--;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_tick();
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
  endtask

  task automatic play_tick();
    do_tick();
    step(7);
  endtask

  task automatic restart_pulse();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
    tests_run++; if (flash_read !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_flash_read got %b want 0", flash_read); end
    tests_run++; if (flash_addr !== 23'd0) begin tests_failed++; $display("[TB] FAIL reset_flash_addr got %h want 0", flash_addr); end
    tests_run++; if (audio_data !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_audio_data got %h want 0", audio_data); end
    tests_run++; if (audio_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_audio_valid got %b want 0", audio_valid); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overrun got %b want 0", overrun); end
  endtask

  task automatic test_forward();
    start = 1'b1;
    direction = 1'b1;
    do_tick();
    tests_run++; if (flash_read !== 1'b1) begin tests_failed++; $display("[TB] FAIL fwd_read_latency got %b want 1", flash_read); end
    step(7);
    tests_run++; if (last_rd_addr !== 23'd0) begin tests_failed++; $display("[TB] FAIL fwd_read_addr got %h want 0", last_rd_addr); end
    tests_run++; if (last_audio !== 16'hAAAA) begin tests_failed++; $display("[TB] FAIL fwd_first_half got %h want AAAA", last_audio); end
    tests_run++; if (av_count !== 1) begin tests_failed++; $display("[TB] FAIL fwd_valid_count1 got %0d want 1", av_count); end
    play_tick();
    tests_run++; if (last_audio !== 16'hBBBB) begin tests_failed++; $display("[TB] FAIL fwd_second_half got %h want BBBB", last_audio); end
    tests_run++; if (flash_addr !== 23'd1) begin tests_failed++; $display("[TB] FAIL fwd_advance got %h want 1", flash_addr); end
    tests_run++; if (av_count !== 2) begin tests_failed++; $display("[TB] FAIL fwd_valid_count2 got %0d want 2", av_count); end
  endtask

  task automatic test_backward();
    repeat (8) play_tick();
    tests_run++; if (flash_addr !== 23'd5) begin tests_failed++; $display("[TB] FAIL bwd_reach5 got %h want 5", flash_addr); end
    direction = 1'b0;
    play_tick();
    tests_run++; if (last_audio !== 16'h2222) begin tests_failed++; $display("[TB] FAIL bwd_first_half got %h want 2222", last_audio); end
    play_tick();
    tests_run++; if (last_audio !== 16'h1111) begin tests_failed++; $display("[TB] FAIL bwd_second_half got %h want 1111", last_audio); end
    tests_run++; if (flash_addr !== 23'd4) begin tests_failed++; $display("[TB] FAIL bwd_advance got %h want 4", flash_addr); end
    play_tick();
    tests_run++; if (last_rd_addr !== 23'd4) begin tests_failed++; $display("[TB] FAIL bwd_next_read got %h want 4", last_rd_addr); end
  endtask

  task automatic test_wrap();
    int rd_before;
    int av_before;
    direction = 1'b0;
    restart_pulse();
    tests_run++; if (flash_addr !== LAST) begin tests_failed++; $display("[TB] FAIL wrap_load_last got %h want %h", flash_addr, LAST); end
    direction = 1'b1;
    play_tick();
    tests_run++; if (last_rd_addr !== LAST) begin tests_failed++; $display("[TB] FAIL wrap_read_last got %h want %h", last_rd_addr, LAST); end
    av_before = av_count;
    play_tick();
    tests_run++; if (av_count !== av_before + 1) begin tests_failed++; $display("[TB] FAIL wrap_last_second_half got %0d want %0d", av_count, av_before + 1); end
`ifdef PLAYBACK_CTRL_LOOP_EN
    tests_run++; if (flash_addr !== 23'd0) begin tests_failed++; $display("[TB] FAIL wrap_addr got %h want 0", flash_addr); end
    play_tick();
    tests_run++; if (last_rd_addr !== 23'd0) begin tests_failed++; $display("[TB] FAIL wrap_read0 got %h want 0", last_rd_addr); end
`else
    tests_run++; if (flash_addr !== LAST) begin tests_failed++; $display("[TB] FAIL stop_addr got %h want %h", flash_addr, LAST); end
    rd_before = rd_count;
    av_before = av_count;
    play_tick();
    play_tick();
    tests_run++; if (rd_count !== rd_before) begin tests_failed++; $display("[TB] FAIL stop_no_read got %0d want %0d", rd_count, rd_before); end
    tests_run++; if (av_count !== av_before) begin tests_failed++; $display("[TB] FAIL stop_no_audio got %0d want %0d", av_count, av_before); end
`endif
    restart_pulse();
    tests_run++; if (flash_addr !== 23'd0) begin tests_failed++; $display("[TB] FAIL wrap_restart_addr got %h want 0", flash_addr); end
  endtask

  task automatic test_overrun();
    int av_before;
    stall_left = 3;
    lat_extra = 2;
    av_before = av_count;
    do_tick();
    step(4);
    do_tick();
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL overrun_set got %b want 1", overrun); end
    step(6);
    tests_run++; if (addr_glitch !== 0) begin tests_failed++; $display("[TB] FAIL addr_stable got %0d changes want 0", addr_glitch); end
    tests_run++; if (last_audio !== 16'hAAAA) begin tests_failed++; $display("[TB] FAIL overrun_first_half got %h want AAAA", last_audio); end
    tests_run++; if (av_count !== av_before + 1) begin tests_failed++; $display("[TB] FAIL overrun_valid_count got %0d want %0d", av_count, av_before + 1); end
    lat_extra = 0;
    play_tick();
    tests_run++; if (last_audio !== 16'hBBBB) begin tests_failed++; $display("[TB] FAIL overrun_second_half got %h want BBBB", last_audio); end
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL overrun_sticky got %b want 1", overrun); end
  endtask

  task automatic test_restart_wait();
    int av_before;
    direction = 1'b1;
    lat_extra = 3;
    av_before = av_count;
    do_tick();
    step(1);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(8);
    tests_run++; if (av_count !== av_before) begin tests_failed++; $display("[TB] FAIL restart_discard got %0d want %0d", av_count, av_before); end
    tests_run++; if (flash_addr !== 23'd0) begin tests_failed++; $display("[TB] FAIL restart_addr got %h want 0", flash_addr); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL restart_overrun_clear got %b want 0", overrun); end
    lat_extra = 0;
    play_tick();
    tests_run++; if (last_rd_addr !== 23'd0) begin tests_failed++; $display("[TB] FAIL restart_next_read got %h want 0", last_rd_addr); end
    tests_run++; if (last_audio !== 16'hAAAA) begin tests_failed++; $display("[TB] FAIL restart_next_audio got %h want AAAA", last_audio); end
  endtask

  task automatic test_pause();
    int av_before;
    int rd_before;
    av_before = av_count;
    rd_before = rd_count;
    start = 1'b0;
    repeat (10) play_tick();
    tests_run++; if (av_count !== av_before) begin tests_failed++; $display("[TB] FAIL pause_no_audio got %0d want %0d", av_count, av_before); end
    tests_run++; if (flash_addr !== 23'd0) begin tests_failed++; $display("[TB] FAIL pause_addr got %h want 0", flash_addr); end
    tests_run++; if (rd_count !== rd_before) begin tests_failed++; $display("[TB] FAIL pause_no_read got %0d want %0d", rd_count, rd_before); end
    start = 1'b1;
    play_tick();
    tests_run++; if (last_audio !== 16'hBBBB) begin tests_failed++; $display("[TB] FAIL resume_half got %h want BBBB", last_audio); end
    tests_run++; if (av_count !== av_before + 1) begin tests_failed++; $display("[TB] FAIL resume_count got %0d want %0d", av_count, av_before + 1); end
    tests_run++; if (flash_addr !== 23'd1) begin tests_failed++; $display("[TB] FAIL resume_addr got %h want 1", flash_addr); end
  endtask

  task automatic test_restart_tick();
    int av_before;
    play_tick();
    tests_run++; if (last_audio !== 16'h0001) begin tests_failed++; $display("[TB] FAIL rt_first_half got %h want 0001", last_audio); end
    av_before = av_count;
    restart = 1'b1;
    sample_tick = 1'b1;
    step(1);
    restart = 1'b0;
    sample_tick = 1'b0;
    step(4);
    tests_run++; if (av_count !== av_before) begin tests_failed++; $display("[TB] FAIL rt_no_sample got %0d want %0d", av_count, av_before); end
    tests_run++; if (flash_addr !== 23'd0) begin tests_failed++; $display("[TB] FAIL rt_addr got %h want 0", flash_addr); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_backward();
    test_wrap();
    test_overrun();
    test_restart_wait();
    test_pause();
    test_restart_tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/playback_ctrl.md
# playback_ctrl

Sequencer between the keyboard command decoder and the flash/audio datapath of the simple iPod. Consumes the decoded `start`, `direction` and `restart` levels plus an audio-rate tick. Issues one 32-bit flash word read per two ticks and emits one 16-bit audio sample per tick, walking the flash forward or backward with wrap-around.

## Interface
- `ADDR_W`, 23: flash word-address width
- `LAST_ADDR`, 23'h7FFFF: last valid word address of the song
- `clk` in 1: system clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: level; 1 = play, 0 = pause
- `direction` in 1: level; 1 = forward, 0 = backward
- `restart` in 1: level/pulse; request return to song start
- `sample_tick` in 1: one-cycle pulse at audio rate, already in `clk` domain
- `flash_read` out 1: read request, held until accepted
- `flash_addr` out ADDR_W: word address, stable while `flash_read` high
- `flash_waitrequest` in 1: slave stall; request accepted on cycle with `flash_read`=1, `flash_waitrequest`=0
- `flash_readdatavalid` in 1: one-cycle data strobe
- `flash_readdata` in 32: read word
- `audio_data` out 16: current sample, holds between updates
- `audio_valid` out 1: one-cycle pulse when `audio_data` updates
- `overrun` out 1: sticky; tick arrived while a flash read was outstanding

## Operation
- States: IDLE, REQ, WAIT_DATA, HALF.
- IDLE: `sample_tick`&`start` -> REQ.
- REQ: `flash_read`=1. Accepted -> WAIT_DATA.
- WAIT_DATA: on `flash_readdatavalid`, latch word. Emit first half (forward: [15:0]; backward: [31:16]). Record half order. -> HALF.
- HALF: `sample_tick`&`start` -> emit other half, advance address, -> IDLE.
- Advance: forward `LAST_ADDR`->0, else +1; backward 0->`LAST_ADDR`, else -1. `direction` sampled at the advance cycle.
- Pause (`start`=0): ticks ignored in IDLE/HALF. An in-flight read completes, and its first half is emitted normally.
- Restart: sets `restart_pend`.
  - In IDLE/HALF: applied next cycle. Address loads 0 (forward) or `LAST_ADDR` (backward), remaining half dropped, -> IDLE, `overrun` cleared.
  - In REQ/WAIT_DATA: the read completes, its data is discarded (no `audio_valid`), then applied the same way.
- `overrun`: set by `sample_tick` in REQ or WAIT_DATA; cleared only by reset or applied restart. The tick is otherwise ignored.
- Simultaneous tick and restart in IDLE/HALF: restart wins, no sample emitted.

## Timing
- Reset values: `flash_read`=0, `flash_addr`=0, `audio_data`=0, `audio_valid`=0, `overrun`=0, state IDLE, `restart_pend`=0.
- Tick in IDLE at cycle N -> `flash_read`=1 at N+1.
- `flash_readdatavalid` at cycle M -> `audio_valid`=1 and new `audio_data` at M+1.
- Tick in HALF at cycle K -> `audio_valid`=1 and new `flash_addr` at K+1.
- `flash_addr` changes only in IDLE, never while `flash_read`=1.
- Exactly one outstanding read at any time.

## Configuration
- `PLAYBACK_CTRL_LOOP_EN` defined: wrap-around as above (song loops).
- Not defined: an advance past the end sets internal `stopped` and leaves the address unchanged. End means forward at `LAST_ADDR` or backward at 0. While `stopped`, ticks are ignored; only restart or reset clears it.

## Structure
- `playback_pkg`: state enum, `DIR_FWD`/`DIR_BWD` constants, half-select encoding.
- One sub-module, `addr_counter`: up/down counter with load, enable and wrap/stop at 0 and `LAST_ADDR`.

## Test plan
- Reset, `start`=1, `direction`=1. Word 0 = 32'hBBBB_AAAA, zero-wait slave.
  - Tick 1 -> read at addr 0; `audio_data`=16'hAAAA.
  - Tick 2 -> `audio_data`=16'hBBBB; `flash_addr`=1.
- `direction`=0 at addr 5, word 32'h2222_1111 -> 16'h2222 then 16'h1111; next read at addr 4.
- Forward at `LAST_ADDR`, two ticks:
  - with `PLAYBACK_CTRL_LOOP_EN`, next read at addr 0;
  - without it, no further `flash_read` on later ticks.
- `flash_waitrequest` held 3 cycles, tick issued during WAIT_DATA:
  - `flash_addr` stable while `flash_read`=1;
  - `overrun`=1 and stays 1 until restart.
- Restart during WAIT_DATA, `direction`=1:
  - no `audio_valid` for that word;
  - next read at addr 0; `overrun`=0.
- `start`=0 in HALF for 10 ticks: no `audio_valid`, address frozen. `start`=1 plus one tick: second half emitted.
